// File: rtl/mic_frame_energy.sv
// mic_frame_energy: frame energy engine for the acoustic camera sample buffers.
//
// After a start pulse, reads FRAME_LEN signed samples from port B of a
// simple-dual-port sample RAM (one-cycle read latency). Each sample is squared
// and the squares are summed. The unsigned frame energy is then held on a
// valid/ready output until the consumer accepts it.
//
// Optional feature, enabled by defining the macro ENERGY_PEAK_EN:
//   track max |sample| of the frame on 'peak'. Without the macro, peak is tied to 0.
//
// Ports:
//   clk          in   single clock, also drives the RAM's clkb
//   reset        in   asynchronous, active-high; clears all state
//   start        in   one-cycle request, honoured only when idle
//   start_adr    in   first sample address of the frame
//   rd_ceb       out  RAM read clock enable
//   rd_oce       out  RAM output enable, constant 1
//   rd_adb       out  RAM read address
//   rd_dout      in   RAM read data, valid one cycle after rd_ceb/rd_adb
//   busy         out  high from the start edge until energy is accepted
//   energy       out  sum of squares of the frame
//   peak         out  max |sample| of the frame (0 when ENERGY_PEAK_EN is undefined)
//   energy_valid out  energy/peak valid; held until accepted
//   energy_ready in   consumer accepts while energy_valid is high
module mic_frame_energy #(
  parameter int unsigned ADDR_W    = 9,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned FRAME_LEN = 512,
  parameter int unsigned ACC_W     = 40
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_adr,
  output logic              rd_ceb,
  output logic              rd_oce,
  output logic [ADDR_W-1:0] rd_adb,
  input  logic [DATA_W-1:0] rd_dout,
  output logic              busy,
  output logic [ACC_W-1:0]  energy,
  output logic [DATA_W-1:0] peak,
  output logic              energy_valid,
  input  logic              energy_ready
);

  localparam int unsigned CntW = ADDR_W + 1;
  localparam logic [CntW-1:0] LastIdx = CntW'(FRAME_LEN - 1);
  localparam int unsigned SqW = 2 * DATA_W;

  typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [1:0]        drain_q, drain_d;
  logic              rd_ceb_q, rd_ceb_d;
  logic [ADDR_W-1:0] rd_adb_q, rd_adb_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic              clear_acc;

  // Pipeline: stage 2 valid (RAM data), stage 3 square, stage 4 accumulator.
  logic              dat_v_q;
  logic              sq_v_q;
  logic [SqW-1:0]    sq_q;
  logic [ACC_W-1:0]  acc_q;
  logic signed [SqW-1:0] sq_d;

  // Signed square is never negative, so it is zero-extended into the accumulator.
  assign sq_d = $signed(rd_dout) * $signed(rd_dout);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    drain_d   = drain_q;
    rd_ceb_d  = rd_ceb_q;
    rd_adb_d  = rd_adb_q;
    busy_d    = busy_q;
    valid_d   = valid_q;
    clear_acc = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StRead;
          rd_ceb_d  = 1'b1;
          rd_adb_d  = start_adr;
          cnt_d     = '0;
          busy_d    = 1'b1;
          clear_acc = 1'b1;
        end
      end
      StRead: begin
        // cnt_q indexes the address currently presented to the RAM.
        if (cnt_q == LastIdx) begin
          state_d  = StDrain;
          rd_ceb_d = 1'b0;
          drain_d  = '0;
        end else begin
          cnt_d    = cnt_q + CntW'(1);
          rd_adb_d = rd_adb_q + ADDR_W'(1);
        end
      end
      StDrain: begin
        // Three cycles cover the RAM, square and accumulate stages.
        if (drain_q == 2'd2) begin
          state_d = StDone;
          valid_d = 1'b1;
        end else begin
          drain_d = drain_q + 2'd1;
        end
      end
      StDone: begin
        if (energy_ready) begin
          state_d = StIdle;
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      drain_q  <= '0;
      rd_ceb_q <= 1'b0;
      rd_adb_q <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      drain_q  <= drain_d;
      rd_ceb_q <= rd_ceb_d;
      rd_adb_q <= rd_adb_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dat_v_q <= 1'b0;
      sq_v_q  <= 1'b0;
      sq_q    <= '0;
      acc_q   <= '0;
    end else begin
      dat_v_q <= rd_ceb_q;
      sq_v_q  <= dat_v_q;
      if (dat_v_q) begin
        sq_q <= sq_d;
      end
      if (clear_acc) begin
        acc_q <= '0;
      end else if (sq_v_q) begin
        acc_q <= acc_q + {{(ACC_W - SqW){1'b0}}, sq_q};
      end
    end
  end

`ifdef ENERGY_PEAK_EN
  logic [DATA_W-1:0] abs_d, abs_q, peak_q;

  // |-2^(DATA_W-1)| wraps to 2^(DATA_W-1), which is exact when read as unsigned.
  assign abs_d = rd_dout[DATA_W-1] ? (~rd_dout + DATA_W'(1)) : rd_dout;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      abs_q  <= '0;
      peak_q <= '0;
    end else begin
      if (dat_v_q) begin
        abs_q <= abs_d;
      end
      if (clear_acc) begin
        peak_q <= '0;
      end else if (sq_v_q && (abs_q > peak_q)) begin
        peak_q <= abs_q;
      end
    end
  end

  assign peak = peak_q;
`else
  assign peak = '0;
`endif

  assign rd_ceb       = rd_ceb_q;
  assign rd_oce       = 1'b1;
  assign rd_adb       = rd_adb_q;
  assign busy         = busy_q;
  assign energy       = acc_q;
  assign energy_valid = valid_q;

endmodule

// File: tb/tb_mic_frame_energy.sv
module tb_mic_frame_energy;

  localparam int unsigned ADDR_W    = 9;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned FRAME_LEN = 512;
  localparam int unsigned ACC_W     = 40;
  localparam int unsigned Depth     = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] start_adr;
  logic              rd_ceb;
  logic              rd_oce;
  logic [ADDR_W-1:0] rd_adb;
  logic [DATA_W-1:0] rd_dout;
  logic              busy;
  logic [ACC_W-1:0]  energy;
  logic [DATA_W-1:0] peak;
  logic              energy_valid;
  logic              energy_ready;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_energy_q[$];
  logic [63:0] exp_peak_q[$];

  logic [DATA_W-1:0] mem [Depth];

  // Address monitor: records what the RAM actually sees on each edge.
  logic              mon_clr;
  logic [ADDR_W-1:0] mon_base;
  logic [ADDR_W-1:0] mon_exp_adr;
  int                issue_cnt [Depth];
  int                order_err;

  always #5 clk = ~clk;

  mic_frame_energy #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .FRAME_LEN(FRAME_LEN),
    .ACC_W    (ACC_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .start_adr   (start_adr),
    .rd_ceb      (rd_ceb),
    .rd_oce      (rd_oce),
    .rd_adb      (rd_adb),
    .rd_dout     (rd_dout),
    .busy        (busy),
    .energy      (energy),
    .peak        (peak),
    .energy_valid(energy_valid),
    .energy_ready(energy_ready)
  );

  // Sample RAM read port B, one-cycle latency.
  always @(posedge clk) begin
    if (rd_ceb) rd_dout <= mem[rd_adb];
  end

  always @(posedge clk) begin
    if (mon_clr) begin
      for (int i = 0; i < int'(Depth); i++) issue_cnt[i] = 0;
      order_err   = 0;
      mon_exp_adr = mon_base;
    end else if (rd_ceb) begin
      if (rd_adb !== mon_exp_adr) order_err++;
      issue_cnt[rd_adb]++;
      mon_exp_adr = mon_exp_adr + 1'b1;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push_expected(input logic [ADDR_W-1:0] adr);
    longint unsigned e;
    longint          pk;
    longint          sv;
    logic [ADDR_W-1:0] a;
    e  = 0;
    pk = 0;
    for (int k = 0; k < int'(FRAME_LEN); k++) begin
      a  = adr + ADDR_W'(k);
      sv = $signed(mem[a]);
      e  = e + longint'(sv * sv);
      if (sv < 0) sv = -sv;
      if (sv > pk) pk = sv;
    end
    exp_energy_q.push_back(e);
`ifdef ENERGY_PEAK_EN
    exp_peak_q.push_back(pk);
`else
    exp_peak_q.push_back(64'd0);
`endif
  endtask

  task automatic run_frame(input logic [ADDR_W-1:0] adr, input bit hold);
    int          cyc;
    int          bad;
    logic [63:0] exp_e;
    logic [63:0] exp_p;
    push_expected(adr);
    @(negedge clk);
    mon_clr  = 1'b1;
    mon_base = adr;
    @(negedge clk);
    mon_clr      = 1'b0;
    energy_ready = !hold;
    start_adr    = adr;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("busy_after_start", busy, 1);
    check_eq("first_adr", rd_adb, adr);
    cyc = 0;
    while (!energy_valid && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      // A start mid-frame must be ignored.
      if (cyc == 100) begin
        start     = 1'b1;
        start_adr = adr + 9'd7;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check_eq("valid_latency", cyc, FRAME_LEN + 3);
    exp_e = exp_energy_q.pop_front();
    exp_p = exp_peak_q.pop_front();
    check_eq("energy", energy, exp_e);
    check_eq("peak", peak, exp_p);
    if (hold) begin
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        start = (i == 3);
        check_eq("hold_valid", energy_valid, 1);
        check_eq("hold_energy", energy, exp_e);
        check_eq("hold_busy", busy, 1);
      end
      // Accept and start together in DONE: start must be ignored.
      energy_ready = 1'b1;
      start        = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check_eq("post_ack_valid", energy_valid, 0);
      check_eq("post_ack_busy", busy, 0);
      check_eq("post_ack_ceb", rd_ceb, 0);
    end else begin
      @(negedge clk);
      check_eq("post_ack_valid", energy_valid, 0);
      check_eq("post_ack_busy", busy, 0);
    end
    bad = 0;
    for (int i = 0; i < int'(Depth); i++) begin
      if (i < int'(FRAME_LEN) && issue_cnt[i] != 1) bad++;
    end
    check_eq("addr_issued_once", bad, 0);
    check_eq("addr_order", order_err, 0);
  endtask

  initial begin
    int cyc;
    reset        = 1'b1;
    start        = 1'b0;
    start_adr    = '0;
    energy_ready = 1'b1;
    mon_clr      = 1'b1;
    mon_base     = '0;
    for (int i = 0; i < int'(Depth); i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    reset   = 1'b0;
    mon_clr = 1'b0;
    @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ceb", rd_ceb, 0);
    check_eq("rst_adb", rd_adb, 0);
    check_eq("rst_energy", energy, 0);
    check_eq("rst_peak", peak, 0);
    check_eq("rst_valid", energy_valid, 0);
    check_eq("rd_oce", rd_oce, 1);

    // All ones: energy 512.
    for (int i = 0; i < int'(Depth); i++) mem[i] = 16'd1;
    run_frame(9'd0, 1'b0);

    // Worst case magnitude: 2^39, no overflow.
    for (int i = 0; i < int'(Depth); i++) mem[i] = 16'h8000;
    run_frame(9'd0, 1'b0);

    // +3/-3 alternating, wrapping frame, consumer stalls.
    for (int i = 0; i < int'(Depth); i++) mem[i] = (i % 2 == 0) ? 16'd3 : 16'hFFFD;
    run_frame(9'd500, 1'b1);

    // Abort mid-frame with reset.
    for (int i = 0; i < int'(Depth); i++) mem[i] = 16'd1000 + DATA_W'(i);
    start_adr = '0;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 0;
    while (rd_adb != 9'd200 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("abort_reached_200", rd_adb, 200);
    reset = 1'b1;
    #1;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_ceb", rd_ceb, 0);
    check_eq("abort_adb", rd_adb, 0);
    check_eq("abort_energy", energy, 0);
    check_eq("abort_peak", peak, 0);
    check_eq("abort_valid", energy_valid, 0);
    @(negedge clk);
    reset = 1'b0;

    // Fresh frame after abort, random data.
    for (int i = 0; i < int'(Depth); i++) mem[i] = DATA_W'($urandom);
    run_frame(9'd37, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
